uart_tx_ctrl: RTL

UART transmit sequencer that owns the baud-rate divider (`clk_div`) and serialises one byte per frame onto `txd`. It accepts bytes from the PicoRV32-side peripheral logic over a valid/ready handshake. It gates the divider with `bps_start`, loads the divisor, consumes `clk_bps` ticks, and walks start, data, optional parity and stop bits. It sits between the UART register file and the `clk_div` instance in the logic-analysis/UART path.

---
 rtl/uart_tx_ctrl_if.sv | 14 +
 rtl/uart_tx_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the UART register file (master) and uart_tx_ctrl (slave).
//   tx_data  : byte to send, sampled when tx_valid & tx_ready at a rising edge
//   tx_valid : requester has a byte
//   tx_ready : transmitter is idle and can accept
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: gates and loads the baud divider, consumes its
// ticks and serialises one byte per frame (start, data LSB first, optional
// parity, one or two stop bits) onto txd.
// Optional feature macro: UART_TX_PARITY_EN (adds cfg_parity_odd and a parity bit).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : uart_tx_ctrl_if slave (tx_data / tx_valid / tx_ready)
//   tx_abort       : drop the current frame, return to idle
//   cfg_div        : baud divisor, sampled on accept
//   cfg_stop2      : two stop bits when 1, sampled on accept
//   cfg_parity_odd : odd parity when 1, sampled on accept (macro only)
//   bps_tick       : bit-period tick from clk_div
//   bps_start      : divider enable to clk_div
//   bps_div        : latched divisor to clk_div
//   txd            : serial line, idle high
//   tx_busy        : inverse of tx_ready
//   tx_done        : one-cycle pulse when a frame completes normally
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_ctrl_if.slave        bus,
  input  logic                 tx_abort,
  input  logic [31:0]          cfg_div,
  input  logic                 cfg_stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                 cfg_parity_odd,
`endif
  input  logic                 bps_tick,
  output logic                 bps_start,
  output logic [31:0]          bps_div,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       div_q, div_d;
  logic              stop2_q, stop2_d;
  logic              stop_seen_q, stop_seen_d;
  logic              txd_q, txd_d;
  logic              bps_start_q, bps_start_d;
  logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      stop2_q     <= 1'b0;
      stop_seen_q <= 1'b0;
      txd_q       <= 1'b1;
      bps_start_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      stop2_q     <= stop2_d;
      stop_seen_q <= stop_seen_d;
      txd_q       <= txd_d;
      bps_start_q <= bps_start_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    stop2_d     = stop2_q;
    stop_seen_d = stop_seen_q;
    txd_d       = txd_q;
    bps_start_d = bps_start_q;
    done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        txd_d       = 1'b1;
        bps_start_d = 1'b0;
        if (bus.tx_valid) begin
          shift_d     = bus.tx_data;
          div_d       = cfg_div;
          stop2_d     = cfg_stop2;
          stop_seen_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_START;
          txd_d       = 1'b0;
          bps_start_d = 1'b1;
`ifdef UART_TX_PARITY_EN
          // Parity is fixed at accept since the shift register is consumed
          par_d       = (^bus.tx_data) ^ cfg_parity_odd;
`endif
        end
      end
      S_START: begin
        if (bps_tick) begin
          state_d = S_DATA;
          cnt_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bps_tick) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          txd_d   = shift_d[0];
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bps_tick) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bps_tick) begin
          if (stop2_q && !stop_seen_q) begin
            stop_seen_d = 1'b1;
          end else begin
            state_d     = S_IDLE;
            bps_start_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        txd_d       = 1'b1;
        bps_start_d = 1'b0;
      end
    endcase

    // Abort wins over any tick in the same cycle
    if (tx_abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      txd_d       = 1'b1;
      bps_start_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  assign bus.tx_ready = (state_q == S_IDLE);
  assign tx_busy      = (state_q != S_IDLE);
  assign txd          = txd_q;
  assign bps_start    = bps_start_q;
  assign bps_div      = div_q;
  assign tx_done      = done_q;

endmodule
